zb_param_fifo: RTL and testbench

// - Parametrised synchronous FIFO. Successor to the fixed 4-bit chip FIFOs on the input and output sides of the transceiver chain.
// - Configurable width and depth; almost-full/almost-empty thresholds; occupancy count; flush; sticky error flags.
// - Instantiated in TOP in place of the inFIFO and the outFIFO. It is reached through the same DEMUX/MUX test access for stand-alone test.

---
 rtl/zb_fifo_pkg.sv | 39 +++
 rtl/zb_fifo_mem.sv | 28 ++
 rtl/zb_param_fifo.sv | 143 ++++++++++++++
 tb/tb_zb_param_fifo.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/zb_fifo_pkg.sv
// Shared types and helpers for the parametrised FIFO (zb_param_fifo).
// Optional first-word fall-through mode is selected with ZB_FIFO_FWFT_EN.
package zb_fifo_pkg;

    localparam int ZB_MAX_WIDTH = 32;

    // Widest word any instance may carry; instances narrow it to WIDTH.
    typedef logic [ZB_MAX_WIDTH-1:0] fifo_word_max_t;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
        logic ovf;
        logic udf;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RESET = '{
        full:   1'b0,
        empty:  1'b1,
        afull:  1'b0,
        aempty: 1'b1,
        ovf:    1'b0,
        udf:    1'b0
    };

    function automatic int clog2_depth(input int depth);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < depth) begin
                bits = i + 1;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/zb_fifo_mem.sv
// Simple dual-port register array for zb_param_fifo: one synchronous write
// port, one combinational read port, no reset on the storage.
module zb_fifo_mem
    import zb_fifo_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 16
) (
    input  logic                           clock,
    input  logic                           writeEnable,
    input  logic [clog2_depth(DEPTH)-1:0]  writeAddr,
    input  logic [WIDTH-1:0]               writeData,
    input  logic [clog2_depth(DEPTH)-1:0]  readAddr,
    output logic [WIDTH-1:0]               readData
);

    logic [WIDTH-1:0] memArray_r [DEPTH];

    // Storage write port; contents survive reset and flush by design.
    always_ff @(posedge clock) begin
        if (writeEnable) begin
            memArray_r[writeAddr] <= writeData;
        end
    end

    assign readData = memArray_r[readAddr];

endmodule

// File: rtl/zb_param_fifo.sv
// Parametrised synchronous FIFO with count, almost flags, flush and sticky
// overflow/underflow. Define ZB_FIFO_FWFT_EN for first-word fall-through.
module zb_param_fifo
    import zb_fifo_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 4
) (
    input  logic                            inClock,
    input  logic                            inReset,
    input  logic                            inFlush,
    input  logic [WIDTH-1:0]                inData,
    input  logic                            inWriteEnable,
    input  logic                            inReadEnable,
    output logic [WIDTH-1:0]                outData,
    output logic                            outValid,
    output logic                            outFull,
    output logic                            outEmpty,
    output logic                            outAlmostFull,
    output logic                            outAlmostEmpty,
    output logic [clog2_depth(DEPTH):0]     outCount,
    output logic                            outOverflow,
    output logic                            outUnderflow
);

    localparam int ADDR_W = clog2_depth(DEPTH);
    localparam int PTR_W  = ADDR_W + 1;
    localparam logic [PTR_W-1:0] DEPTH_C = PTR_W'(DEPTH);
    localparam logic [PTR_W-1:0] AF_C    = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_C    = PTR_W'(AE_LEVEL);
    localparam logic [PTR_W-1:0] ONE_C   = PTR_W'(1'b1);

    typedef logic [WIDTH-1:0] fifo_word_t;

    logic [PTR_W-1:0] wrPtr_r;
    logic [PTR_W-1:0] rdPtr_r;
    logic [PTR_W-1:0] count_r;
    fifo_flags_t      flags_r;

    logic [PTR_W-1:0] wrPtrNext_s;
    logic [PTR_W-1:0] rdPtrNext_s;
    logic [PTR_W-1:0] countNext_s;
    fifo_flags_t      flagsNext_s;
    logic             rdOk_s;
    logic             wrOk_s;
    logic             memWe_s;
    fifo_word_t       memRdData_s;

    // Accept decisions, next pointers, and flags derived from the next count.
    always_comb begin
        rdOk_s  = inReadEnable && !flags_r.empty;
        wrOk_s  = inWriteEnable && (!flags_r.full || rdOk_s);
        memWe_s = wrOk_s && !inFlush;

        if (inFlush) begin
            wrPtrNext_s = '0;
            rdPtrNext_s = '0;
        end else begin
            wrPtrNext_s = wrOk_s ? (wrPtr_r + ONE_C) : wrPtr_r;
            rdPtrNext_s = rdOk_s ? (rdPtr_r + ONE_C) : rdPtr_r;
        end

        // The extra pointer MSB makes this difference span 0..DEPTH exactly.
        countNext_s = wrPtrNext_s - rdPtrNext_s;

        flagsNext_s.full   = (countNext_s == DEPTH_C);
        flagsNext_s.empty  = (countNext_s == '0);
        flagsNext_s.afull  = (countNext_s >= AF_C);
        flagsNext_s.aempty = (countNext_s <= AE_C);
        if (inFlush) begin
            flagsNext_s.ovf = 1'b0;
            flagsNext_s.udf = 1'b0;
        end else begin
            flagsNext_s.ovf = flags_r.ovf || (inWriteEnable && flags_r.full && !rdOk_s);
            flagsNext_s.udf = flags_r.udf || (inReadEnable && flags_r.empty);
        end
    end

    // Pointer, occupancy and flag state.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            wrPtr_r <= '0;
            rdPtr_r <= '0;
            count_r <= '0;
            flags_r <= FLAGS_RESET;
        end else begin
            wrPtr_r <= wrPtrNext_s;
            rdPtr_r <= rdPtrNext_s;
            count_r <= countNext_s;
            flags_r <= flagsNext_s;
        end
    end

    zb_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) uMem (
        .clock       (inClock),
        .writeEnable (memWe_s),
        .writeAddr   (wrPtr_r[ADDR_W-1:0]),
        .writeData   (inData),
        .readAddr    (rdPtr_r[ADDR_W-1:0]),
        .readData    (memRdData_s)
    );

`ifdef ZB_FIFO_FWFT_EN
    // Head word is shown directly; zero while empty keeps reset/flush clean.
    assign outData  = flags_r.empty ? fifo_word_t'(1'b0) : memRdData_s;
    assign outValid = !flags_r.empty;
`else
    fifo_word_t dataOut_r;
    logic       valid_r;

    // Read-data register: captures the popped word, valid pulses per pop.
    always_ff @(posedge inClock or posedge inReset) begin
        if (inReset) begin
            dataOut_r <= '0;
            valid_r   <= 1'b0;
        end else if (inFlush) begin
            valid_r   <= 1'b0;
        end else begin
            valid_r <= rdOk_s;
            if (rdOk_s) begin
                dataOut_r <= memRdData_s;
            end
        end
    end

    assign outData  = dataOut_r;
    assign outValid = valid_r;
`endif

    assign outCount       = count_r;
    assign outFull        = flags_r.full;
    assign outEmpty       = flags_r.empty;
    assign outAlmostFull  = flags_r.afull;
    assign outAlmostEmpty = flags_r.aempty;
    assign outOverflow    = flags_r.ovf;
    assign outUnderflow   = flags_r.udf;

endmodule

// File: tb/tb_zb_param_fifo.sv
// Directed self-checking bench for zb_param_fifo (WIDTH=4, DEPTH=16);
// read-latency expectations follow ZB_FIFO_FWFT_EN when it is defined.
module tb_zb_param_fifo;
    import zb_fifo_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 16;
    localparam int CNT_W = clog2_depth(DEPTH) + 1;

    logic             inClock;
    logic             inReset;
    logic             inFlush;
    logic [WIDTH-1:0] inData;
    logic             inWriteEnable;
    logic             inReadEnable;
    logic [WIDTH-1:0] outData;
    logic             outValid;
    logic             outFull;
    logic             outEmpty;
    logic             outAlmostFull;
    logic             outAlmostEmpty;
    logic [CNT_W-1:0] outCount;
    logic             outOverflow;
    logic             outUnderflow;

    int vectors     = 0;
    int miscompares = 0;

    zb_param_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (12),
        .AE_LEVEL (4)
    ) dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inFlush        (inFlush),
        .inData         (inData),
        .inWriteEnable  (inWriteEnable),
        .inReadEnable   (inReadEnable),
        .outData        (outData),
        .outValid       (outValid),
        .outFull        (outFull),
        .outEmpty       (outEmpty),
        .outAlmostFull  (outAlmostFull),
        .outAlmostEmpty (outAlmostEmpty),
        .outCount       (outCount),
        .outOverflow    (outOverflow),
        .outUnderflow   (outUnderflow)
    );

    initial inClock = 1'b0;
    always #5 inClock = ~inClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge inClock);
        #1;
    endtask

    task automatic checkResetState(input string tag);
        check({tag, " count"},  32'(outCount),       32'd0);
        check({tag, " empty"},  32'(outEmpty),       32'd1);
        check({tag, " aempty"}, 32'(outAlmostEmpty), 32'd1);
        check({tag, " full"},   32'(outFull),        32'd0);
        check({tag, " afull"},  32'(outAlmostFull),  32'd0);
        check({tag, " ovf"},    32'(outOverflow),    32'd0);
        check({tag, " udf"},    32'(outUnderflow),   32'd0);
        check({tag, " data"},   32'(outData),        32'd0);
        check({tag, " valid"},  32'(outValid),       32'd0);
    endtask

    task automatic writeWord(input logic [WIDTH-1:0] d);
        inData        = d;
        inWriteEnable = 1'b1;
        tick();
        inWriteEnable = 1'b0;
    endtask

    // Pop one word and compare it with exp at the mode's read latency.
    task automatic readExpect(input string tag, input logic [WIDTH-1:0] exp);
`ifdef ZB_FIFO_FWFT_EN
        check({tag, " data"},  32'(outData),  32'(exp));
        check({tag, " valid"}, 32'(outValid), 32'd1);
        inReadEnable = 1'b1;
        tick();
        inReadEnable = 1'b0;
`else
        inReadEnable = 1'b1;
        tick();
        inReadEnable = 1'b0;
        check({tag, " data"},  32'(outData),  32'(exp));
        check({tag, " valid"}, 32'(outValid), 32'd1);
`endif
    endtask

    initial begin
        logic [WIDTH-1:0] expWord;

        inReset       = 1'b1;
        inFlush       = 1'b0;
        inData        = '0;
        inWriteEnable = 1'b0;
        inReadEnable  = 1'b0;
        #12;
        checkResetState("reset");
        inReset = 1'b0;
        tick();

        // Fill with 0x1..0xF,0x0.
        for (int i = 1; i <= 16; i++) begin
            writeWord(WIDTH'(i));
            check("fill count",  32'(outCount),       32'(i));
            check("fill afull",  32'(outAlmostFull),  32'(i >= 12));
            check("fill full",   32'(outFull),        32'(i == 16));
            check("fill aempty", 32'(outAlmostEmpty), 32'(i <= 4));
        end
`ifdef ZB_FIFO_FWFT_EN
        check("fill head data",  32'(outData),  32'h1);
        check("fill head valid", 32'(outValid), 32'd1);
`else
        check("fill valid idle", 32'(outValid), 32'd0);
`endif

        // Overflow while full, no read.
        writeWord(4'h5);
        check("ovf flag",  32'(outOverflow), 32'd1);
        check("ovf count", 32'(outCount),    32'd16);
        check("ovf full",  32'(outFull),     32'd1);

        // Drain 16 then one extra read.
        for (int k = 0; k < 16; k++) begin
            readExpect("drain", WIDTH'(k + 1));
            check("drain count", 32'(outCount), 32'(15 - k));
        end
        check("drain empty",    32'(outEmpty),    32'd1);
        check("drain ovf held", 32'(outOverflow), 32'd1);
        inReadEnable = 1'b1;
        tick();
        inReadEnable = 1'b0;
        check("udf flag",  32'(outUnderflow), 32'd1);
        check("udf valid", 32'(outValid),     32'd0);
        check("udf data",  32'(outData),      32'h0);
        check("udf count", 32'(outCount),     32'd0);

        // Simultaneous read+write while full.
        inFlush = 1'b1;
        tick();
        inFlush = 1'b0;
        check("flush1 ovf", 32'(outOverflow),  32'd0);
        check("flush1 udf", 32'(outUnderflow), 32'd0);
        for (int i = 1; i <= 16; i++) begin
            writeWord(WIDTH'(i));
        end
`ifdef ZB_FIFO_FWFT_EN
        check("simfull head pre", 32'(outData), 32'h1);
`endif
        inData        = 4'hA;
        inWriteEnable = 1'b1;
        inReadEnable  = 1'b1;
        tick();
        inWriteEnable = 1'b0;
        inReadEnable  = 1'b0;
        check("simfull count", 32'(outCount),    32'd16);
        check("simfull ovf",   32'(outOverflow), 32'd0);
        check("simfull full",  32'(outFull),     32'd1);
`ifdef ZB_FIFO_FWFT_EN
        check("simfull head post", 32'(outData), 32'h2);
`else
        check("simfull data",  32'(outData),  32'h1);
        check("simfull valid", 32'(outValid), 32'd1);
`endif
        for (int k = 0; k < 16; k++) begin
            if (k < 14) expWord = WIDTH'(k + 2);
            else if (k == 14) expWord = 4'h0;
            else expWord = 4'hA;
            readExpect("simfull drain", expWord);
        end
        check("simfull empty", 32'(outEmpty), 32'd1);

        // Simultaneous read+write while empty.
`ifdef ZB_FIFO_FWFT_EN
        check("simempty valid pre", 32'(outValid), 32'd0);
`endif
        inData        = 4'h3;
        inWriteEnable = 1'b1;
        inReadEnable  = 1'b1;
        tick();
        inWriteEnable = 1'b0;
        inReadEnable  = 1'b0;
        check("simempty count", 32'(outCount),     32'd1);
        check("simempty udf",   32'(outUnderflow), 32'd1);
        check("simempty ovf",   32'(outOverflow),  32'd0);
`ifdef ZB_FIFO_FWFT_EN
        check("simempty valid", 32'(outValid), 32'd1);
        check("simempty data",  32'(outData),  32'h3);
`else
        check("simempty valid", 32'(outValid), 32'd0);
        check("simempty data",  32'(outData),  32'hA);
`endif

        // Flush with a concurrent write at count 7.
        for (int i = 0; i < 6; i++) begin
            writeWord(WIDTH'(i + 8));
        end
        check("preflush count", 32'(outCount),     32'd7);
        check("preflush udf",   32'(outUnderflow), 32'd1);
        inData        = 4'hF;
        inWriteEnable = 1'b1;
        inFlush       = 1'b1;
        tick();
        inWriteEnable = 1'b0;
        inFlush       = 1'b0;
        check("flush count",  32'(outCount),       32'd0);
        check("flush empty",  32'(outEmpty),       32'd1);
        check("flush aempty", 32'(outAlmostEmpty), 32'd1);
        check("flush udf",    32'(outUnderflow),   32'd0);
        check("flush ovf",    32'(outOverflow),    32'd0);
        check("flush full",   32'(outFull),        32'd0);
        check("flush valid",  32'(outValid),       32'd0);

        // Burst then asynchronous reset between clock edges.
        writeWord(4'h9);
        writeWord(4'h7);
        readExpect("burst", 4'h9);
        writeWord(4'h6);
        check("burst count", 32'(outCount), 32'd2);
        inData        = 4'hC;
        inWriteEnable = 1'b1;
        #2;
        inReset = 1'b1;
        #1;
        checkResetState("async reset");
        inWriteEnable = 1'b0;
        inReset       = 1'b0;
        tick();
        checkResetState("post reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
